// File: rtl/axis_golden_checker.sv
// Compares a DUT AXI-Stream against a golden stream beat by beat and reports a final verdict.
// Optional macro GOLDEN_TOL_EN: signed data may differ by up to TOL (absolute) and still match.
module axis_golden_checker #(
    parameter int WIDTH       = 32,
    parameter int LEN         = 33,
    parameter int TIMEOUT     = 4096,
    parameter int STOP_ON_ERR = 1,
    parameter int TOL         = 0,
    localparam int ERR_W      = $clog2(LEN + 1),
    localparam int IDX_W      = (LEN > 1) ? $clog2(LEN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             act_valid,
    input  logic             act_last,
    input  logic [WIDTH-1:0] act_data,
    output logic             act_ready,
    input  logic             exp_valid,
    input  logic             exp_last,
    input  logic [WIDTH-1:0] exp_data,
    output logic             exp_ready,
    output logic [2:0]       result,
    output logic             done,
    output logic [ERR_W-1:0] err_count,
    output logic [IDX_W-1:0] first_err_idx,
    output logic [1:0]       dbg_state
);

    localparam logic [2:0] R_NONE    = 3'd0;
    localparam logic [2:0] R_PASS    = 3'd1;
    localparam logic [2:0] R_DATA    = 3'd2;
    localparam logic [2:0] R_LAST    = 3'd3;
    localparam logic [2:0] R_LENGTH  = 3'd4;
    localparam logic [2:0] R_TIMEOUT = 3'd5;

    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LEN - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(LEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [TO_W-1:0]  idle_cnt;
    logic [2:0]       first_code;

    logic       beat;
    logic       data_ok;
    logic       last_idx;
    logic       len_err;
    logic       last_err;
    logic       beat_err;
    logic [2:0] beat_code;
    logic [2:0] fin_code;

    // Valid/ready: a beat is consumed from both streams together, only while running,
    // and only when both sides present data; one stream never advances alone.
    assign beat      = (state == S_RUN) && act_valid && exp_valid;
    assign act_ready = beat;
    assign exp_ready = beat;
    assign dbg_state = state;

`ifdef GOLDEN_TOL_EN
    localparam logic [WIDTH:0] TOL_V = (WIDTH + 1)'(TOL);
    logic signed [WIDTH:0] diff;
    logic        [WIDTH:0] mag;

    // One extra bit makes the signed difference exact, so its magnitude cannot wrap.
    always_comb begin
        diff    = $signed({act_data[WIDTH-1], act_data}) - $signed({exp_data[WIDTH-1], exp_data});
        mag     = diff[WIDTH] ? $unsigned(-diff) : $unsigned(diff);
        data_ok = (mag <= TOL_V);
    end
`else
    assign data_ok = (act_data == exp_data);
`endif

    // Length errors outrank last-flag errors, which outrank data errors.
    always_comb begin
        last_idx = (idx == IDX_LAST);
        len_err  = last_idx ? !exp_last : exp_last;
        last_err = (act_last != exp_last);
        if (len_err)       beat_code = R_LENGTH;
        else if (last_err) beat_code = R_LAST;
        else if (!data_ok) beat_code = R_DATA;
        else               beat_code = R_NONE;
        beat_err = (beat_code != R_NONE);
        if (first_code != R_NONE) fin_code = first_code;
        else if (beat_err)        fin_code = beat_code;
        else                      fin_code = R_PASS;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            idx           <= '0;
            idle_cnt      <= '0;
            first_code    <= R_NONE;
            result        <= R_NONE;
            done          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state         <= S_RUN;
                        idx           <= '0;
                        idle_cnt      <= '0;
                        first_code    <= R_NONE;
                        err_count     <= '0;
                        first_err_idx <= '0;
                    end
                end
                S_RUN: begin
                    if (beat) begin
                        idle_cnt <= '0;
                        if (!last_idx) idx <= idx + 1'b1;
                        if (beat_err) begin
                            if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
                            if (first_code == R_NONE) begin
                                first_code    <= beat_code;
                                first_err_idx <= idx;
                            end
                        end
                        if ((STOP_ON_ERR != 0 && beat_err) || last_idx) begin
                            state  <= S_DONE;
                            done   <= 1'b1;
                            result <= fin_code;
                        end
                    end else if (TIMEOUT != 0) begin
                        if (idle_cnt == TO_LAST) begin
                            state  <= S_DONE;
                            done   <= 1'b1;
                            result <= R_TIMEOUT;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_golden_checker.sv
// Directed bench: two checkers (stop-on-error and run-to-end) share one stimulus stream.
module tb_axis_golden_checker;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         act_valid = 1'b0;
    logic         act_last = 1'b0;
    logic [W-1:0] act_data = '0;
    logic         exp_valid = 1'b0;
    logic         exp_last = 1'b0;
    logic [W-1:0] exp_data = '0;

    logic       act_ready_a, exp_ready_a, done_a;
    logic [2:0] result_a, err_count_a;
    logic [1:0] first_err_idx_a, dbg_state_a;
    logic       act_ready_b, exp_ready_b, done_b;
    logic [2:0] result_b, err_count_b;
    logic [1:0] first_err_idx_b, dbg_state_b;

    int total = 0;
    int bad = 0;
    logic [2:0] exp_q[$];
    logic [2:0] exp_code;

    axis_golden_checker #(.WIDTH(W), .LEN(4), .TIMEOUT(8), .STOP_ON_ERR(1), .TOL(1)) u_a (
        .clk(clk), .rst(rst), .start(start),
        .act_valid(act_valid), .act_last(act_last), .act_data(act_data), .act_ready(act_ready_a),
        .exp_valid(exp_valid), .exp_last(exp_last), .exp_data(exp_data), .exp_ready(exp_ready_a),
        .result(result_a), .done(done_a), .err_count(err_count_a),
        .first_err_idx(first_err_idx_a), .dbg_state(dbg_state_a)
    );

    axis_golden_checker #(.WIDTH(W), .LEN(4), .TIMEOUT(8), .STOP_ON_ERR(0), .TOL(1)) u_b (
        .clk(clk), .rst(rst), .start(start),
        .act_valid(act_valid), .act_last(act_last), .act_data(act_data), .act_ready(act_ready_b),
        .exp_valid(exp_valid), .exp_last(exp_last), .exp_data(exp_data), .exp_ready(exp_ready_b),
        .result(result_b), .done(done_b), .err_count(err_count_b),
        .first_err_idx(first_err_idx_b), .dbg_state(dbg_state_b)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Driver tasks: every task starts and ends just after a falling edge.
    task automatic reset_all();
        rst = 1'b1; start = 1'b0; act_valid = 1'b0; exp_valid = 1'b0;
        act_last = 1'b0; exp_last = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drive_beat(input logic [W-1:0] a, input logic [W-1:0] e,
                              input logic al, input logic el);
        act_valid = 1'b1; exp_valid = 1'b1;
        act_data = a; exp_data = e; act_last = al; exp_last = el;
        @(posedge clk); @(negedge clk);
        act_valid = 1'b0; exp_valid = 1'b0; act_last = 1'b0; exp_last = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; act_valid = 1'b1; exp_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        total++; if (result_a !== 3'd0 || done_a !== 1'b0) begin bad++; $display("FAIL reset_out_a got=%0d/%0b want=0/0", result_a, done_a); end
        total++; if (err_count_a !== 3'd0 || first_err_idx_a !== 2'd0) begin bad++; $display("FAIL reset_cnt_a got=%0d/%0d want=0/0", err_count_a, first_err_idx_a); end
        total++; if (act_ready_a !== 1'b0 || exp_ready_a !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b%0b want=00", act_ready_a, exp_ready_a); end
        total++; if (dbg_state_a !== 2'd0 || dbg_state_b !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d/%0d want=0/0", dbg_state_a, dbg_state_b); end
        rst = 1'b0; start = 1'b0; act_valid = 1'b0; exp_valid = 1'b0;
    endtask

    task automatic test_pass();
        reset_all();
        start = 1'b1; act_valid = 1'b1; exp_valid = 1'b1; act_data = 8'd1; exp_data = 8'd1;
        #1;
        total++; if (act_ready_a !== 1'b0) begin bad++; $display("FAIL start_cycle_ready got=%0b want=0", act_ready_a); end
        @(posedge clk); @(negedge clk);
        start = 1'b0; act_valid = 1'b0; exp_valid = 1'b0;
        for (int i = 0; i < 3; i++) drive_beat(W'(i + 1), W'(i + 1), 1'b0, 1'b0);
        total++; if (done_a !== 1'b0 || result_a !== 3'd0) begin bad++; $display("FAIL pass_early got=%0b/%0d want=0/0", done_a, result_a); end
        drive_beat(8'd4, 8'd4, 1'b1, 1'b1);
        exp_q.push_back(3'd1);
        exp_code = exp_q.pop_front();
        total++; if (done_a !== 1'b1 || result_a !== exp_code) begin bad++; $display("FAIL pass_a got=%0b/%0d want=1/%0d", done_a, result_a, exp_code); end
        total++; if (done_b !== 1'b1 || result_b !== 3'd1 || err_count_b !== 3'd0) begin bad++; $display("FAIL pass_b got=%0b/%0d/%0d want=1/1/0", done_b, result_b, err_count_b); end
        start = 1'b1; act_valid = 1'b1; exp_valid = 1'b1;
        #1;
        total++; if (act_ready_a !== 1'b0) begin bad++; $display("FAIL done_ready got=%0b want=0", act_ready_a); end
        @(posedge clk); @(negedge clk);
        start = 1'b0; act_valid = 1'b0; exp_valid = 1'b0;
        total++; if (dbg_state_a !== 2'd2 || result_a !== 3'd1) begin bad++; $display("FAIL done_hold got=%0d/%0d want=2/1", dbg_state_a, result_a); end
    endtask

    task automatic test_stop_err();
        reset_all(); do_start();
        drive_beat(8'd1, 8'd1, 1'b0, 1'b0);
        drive_beat(8'd2, 8'd2, 1'b0, 1'b0);
        drive_beat(8'd7, 8'd3, 1'b0, 1'b0);
        total++; if (done_a !== 1'b1 || result_a !== 3'd2 || first_err_idx_a !== 2'd2) begin bad++; $display("FAIL stop_a got=%0b/%0d/%0d want=1/2/2", done_a, result_a, first_err_idx_a); end
        total++; if (done_b !== 1'b0 || err_count_b !== 3'd1) begin bad++; $display("FAIL stop_b_running got=%0b/%0d want=0/1", done_b, err_count_b); end
        act_valid = 1'b1; exp_valid = 1'b1;
        #1;
        total++; if (act_ready_a !== 1'b0 || exp_ready_a !== 1'b0 || act_ready_b !== 1'b1) begin bad++; $display("FAIL stop_ready got=%0b%0b%0b want=001", act_ready_a, exp_ready_a, act_ready_b); end
        drive_beat(8'd4, 8'd4, 1'b1, 1'b1);
        total++; if (done_b !== 1'b1 || result_b !== 3'd2 || first_err_idx_b !== 2'd2) begin bad++; $display("FAIL stop_b_final got=%0b/%0d/%0d want=1/2/2", done_b, result_b, first_err_idx_b); end
    endtask

    task automatic test_multi_err();
        reset_all(); do_start();
        drive_beat(8'd1, 8'd1, 1'b0, 1'b0);
        drive_beat(8'd9, 8'd2, 1'b0, 1'b0);
        drive_beat(8'd3, 8'd3, 1'b0, 1'b0);
        drive_beat(8'd0, 8'd4, 1'b1, 1'b1);
        total++; if (result_b !== 3'd2 || err_count_b !== 3'd2 || first_err_idx_b !== 2'd1) begin bad++; $display("FAIL multi_b got=%0d/%0d/%0d want=2/2/1", result_b, err_count_b, first_err_idx_b); end
        total++; if (result_a !== 3'd2 || err_count_a !== 3'd1 || first_err_idx_a !== 2'd1) begin bad++; $display("FAIL multi_a got=%0d/%0d/%0d want=2/1/1", result_a, err_count_a, first_err_idx_a); end
    endtask

    task automatic test_length();
        reset_all(); do_start();
        drive_beat(8'd1, 8'd1, 1'b0, 1'b0);
        drive_beat(8'd2, 8'd2, 1'b1, 1'b1);
        total++; if (result_a !== 3'd4 || first_err_idx_a !== 2'd1) begin bad++; $display("FAIL length_a got=%0d/%0d want=4/1", result_a, first_err_idx_a); end
        drive_beat(8'd3, 8'd3, 1'b0, 1'b0);
        drive_beat(8'd4, 8'd4, 1'b0, 1'b0);
        total++; if (result_b !== 3'd4 || err_count_b !== 3'd2) begin bad++; $display("FAIL length_b got=%0d/%0d want=4/2", result_b, err_count_b); end
    endtask

    task automatic test_last_mismatch();
        reset_all(); do_start();
        drive_beat(8'd1, 8'd1, 1'b0, 1'b0);
        drive_beat(8'd5, 8'd2, 1'b1, 1'b0);
        total++; if (result_a !== 3'd3 || first_err_idx_a !== 2'd1) begin bad++; $display("FAIL last_a got=%0d/%0d want=3/1", result_a, first_err_idx_a); end
        drive_beat(8'd3, 8'd3, 1'b0, 1'b0);
        drive_beat(8'd4, 8'd4, 1'b0, 1'b1);
        total++; if (result_b !== 3'd3 || err_count_b !== 3'd2 || first_err_idx_b !== 2'd1) begin bad++; $display("FAIL last_b got=%0d/%0d/%0d want=3/2/1", result_b, err_count_b, first_err_idx_b); end
    endtask

    task automatic test_timeout();
        reset_all(); do_start();
        drive_beat(8'd1, 8'd1, 1'b0, 1'b0);
        idle_cycles(7);
        total++; if (done_a !== 1'b0 || done_b !== 1'b0) begin bad++; $display("FAIL timeout_early got=%0b%0b want=00", done_a, done_b); end
        idle_cycles(1);
        total++; if (done_a !== 1'b1 || result_a !== 3'd5 || result_b !== 3'd5) begin bad++; $display("FAIL timeout got=%0b/%0d/%0d want=1/5/5", done_a, result_a, result_b); end
    endtask

    task automatic test_abort();
        reset_all(); do_start();
        drive_beat(8'd1, 8'd1, 1'b0, 1'b0);
        drive_beat(8'd2, 8'd2, 1'b0, 1'b0);
        rst = 1'b1; act_valid = 1'b1; exp_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0; act_valid = 1'b0; exp_valid = 1'b0;
        total++; if (result_a !== 3'd0 || done_a !== 1'b0 || dbg_state_a !== 2'd0) begin bad++; $display("FAIL abort got=%0d/%0b/%0d want=0/0/0", result_a, done_a, dbg_state_a); end
        do_start();
        for (int i = 0; i < 4; i++) drive_beat(W'(i + 1), W'(i + 1), i == 3, i == 3);
        total++; if (result_a !== 3'd1 || err_count_a !== 3'd0) begin bad++; $display("FAIL restart got=%0d/%0d want=1/0", result_a, err_count_a); end
    endtask

    task automatic test_tol();
        reset_all(); do_start();
        drive_beat(8'hFB, 8'hFC, 1'b0, 1'b0);
`ifdef GOLDEN_TOL_EN
        total++; if (done_a !== 1'b0 || err_count_a !== 3'd0) begin bad++; $display("FAIL tol_match got=%0b/%0d want=0/0", done_a, err_count_a); end
        drive_beat(8'd5, 8'd3, 1'b0, 1'b0);
        total++; if (result_a !== 3'd2 || first_err_idx_a !== 2'd1) begin bad++; $display("FAIL tol_miss got=%0d/%0d want=2/1", result_a, first_err_idx_a); end
`else
        total++; if (result_a !== 3'd2 || first_err_idx_a !== 2'd0) begin bad++; $display("FAIL exact_cmp got=%0d/%0d want=2/0", result_a, first_err_idx_a); end
`endif
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_pass();
        test_stop_err();
        test_multi_err();
        test_length();
        test_last_mismatch();
        test_timeout();
        test_abort();
        test_tol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_golden_checker.md
AXIS_GOLDEN_CHECKER -- requirements
Module: axis_golden_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of both streams.
REQ-002 SHALL have parameter LEN, default 33, expected beat count per test (>=1).
REQ-003 SHALL have parameter TIMEOUT, default 4096, max idle cycles in RUN without a beat; 0 disables timeout.
REQ-004 SHALL have parameter STOP_ON_ERR, default 1; 1 = finish at first error, 0 = run to end and count errors.
REQ-005 SHALL have parameter TOL, default 0, absolute tolerance (used only under GOLDEN_TOL_EN).
REQ-006 clk  input  1  clock; all logic on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 start  input  1  begin test; sampled only in IDLE.
REQ-009 act_valid / act_last  input  1 each; act_data  input  WIDTH: DUT output stream.
REQ-010 act_ready  output  1  DUT stream accept.
REQ-011 exp_valid / exp_last  input  1 each; exp_data  input  WIDTH: golden stream.
REQ-012 exp_ready  output  1  golden stream accept.
REQ-013 result  output  3  0 running/idle, 1 PASS, 2 DATA_MISMATCH, 3 LAST_MISMATCH, 4 LENGTH_ERR, 5 TIMEOUT.
REQ-014 done  output  1  high in DONE.
REQ-015 err_count  output  clog2(LEN+1)  data/last mismatches seen; saturates at LEN.
REQ-016 first_err_idx  output  clog2(LEN)  beat index of first error; 0 if none.

Function
REQ-017 FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on completion or error per REQ-022..025; DONE holds until rst.
REQ-018 Joint handshake: act_ready = exp_ready = (state==RUN) && act_valid && exp_valid; beat occurs when both high; never one stream without the other.
REQ-019 Ready SHALL be 0 in IDLE and DONE; no beat consumed in the start cycle.
REQ-020 Beat counter idx (0..LEN-1) increments per beat; compare combinational on the beat, result registered, 1-cycle latency to result/done.
REQ-021 Data compare: exact bit equality (see REQ-033 for tolerance).
REQ-022 act_last != exp_last on a beat -> LAST_MISMATCH; takes priority over data mismatch on the same beat.
REQ-023 Beat idx==LEN-1 with exp_last==0, or exp_last==1 at idx<LEN-1 -> LENGTH_ERR, priority over REQ-022.
REQ-024 Beat with idx==LEN-1 and no error recorded -> PASS; with errors recorded (STOP_ON_ERR=0) -> code of the first error.
REQ-025 STOP_ON_ERR=1: first error -> DONE next cycle with that code; STOP_ON_ERR=0: continue, keep first code/idx, increment err_count.
REQ-026 Idle counter clears on every beat and on RUN entry; reaching TIMEOUT in RUN -> DONE, result TIMEOUT; TIMEOUT takes effect even mid-stream.
REQ-027 result SHALL stay 0 until DONE, then hold final code stable.
REQ-028 start while RUN or DONE SHALL be ignored.

Reset
REQ-029 rst SHALL force IDLE, result=0, done=0, err_count=0, first_err_idx=0, idx=0, idle counter=0, readies 0 in the next cycle.
REQ-030 rst mid-RUN SHALL abort without reporting; a following start restarts at idx 0.
REQ-031 rst SHALL dominate start and beats in the same cycle.

Configuration
REQ-032 Macro GOLDEN_TOL_EN selects tolerant compare.
REQ-033 Defined: data matches iff |act-exp| <= TOL, both signed two's complement, difference computed in WIDTH+1 bits, no overflow.
REQ-034 Undefined: exact compare, TOL ignored, no subtractor synthesised.

Verification
REQ-035 LEN=4, identical streams 1,2,3,4, last on beat 3 -> result=1, done one cycle after beat 3, err_count=0.
REQ-036 STOP_ON_ERR=1, act beat 2 = 7 vs exp 3 -> result=2, first_err_idx=2, no further beats accepted.
REQ-037 STOP_ON_ERR=0, mismatches at beats 1 and 3 of LEN=4 -> result=2, err_count=2, first_err_idx=1.
REQ-038 exp_last on beat 1 of LEN=4 -> result=4; act_last on beat 1, exp_last on 3 -> result=3 at idx 1.
REQ-039 TIMEOUT=8, act_valid stuck 0 after beat 0 -> result=5 after 8 idle cycles; rst mid-RUN -> result=0, idle.
REQ-040 GOLDEN_TOL_EN, TOL=1: act=-5 exp=-4 -> match; act=5 exp=3 -> result=2.
